// File: rtl/adc_serial_responder.sv
// Slave end of the 3-wire serial ADC link: presents a board-supplied sample to an
// external master as a 16-bit frame, with CS_n and SCLK treated as asynchronous inputs.
module adc_serial_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              cs_n_in,
  input  logic              sclk_in,
  output logic              sdata_out,
  output logic              sdata_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [7:0]        frame_count
);

  localparam int FRAME_LEN = LEAD_ZEROS + DATA_W;
  localparam int CNT_RAW   = $clog2(FRAME_LEN + 1);
  localparam int CNT_W     = (CNT_RAW < 5) ? 5 : CNT_RAW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic                   r_cs_hist;
  logic                   r_sclk_hist;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_sdata_out;
  logic                   r_sdata_oe;
  logic                   r_busy;
  logic                   r_frame_done;
  logic                   r_frame_abort;
  logic [7:0]             r_frame_count;

  logic                   w_cs_last;
  logic                   w_sclk_last;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_sclk_fall;
  logic                   w_last_bit;
  logic [FRAME_LEN-1:0]   w_load_word;

  // Synchronizers and history flops idle high, so reset never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '1;
      r_cs_hist   <= 1'b1;
      r_sclk_hist <= 1'b1;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_sclk_sync[i] <= r_sclk_sync[i-1];
      end
      r_cs_sync[0]   <= cs_n_in;
      r_sclk_sync[0] <= sclk_in;
      r_cs_hist      <= r_cs_sync[SYNC_STAGES-1];
      r_sclk_hist    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_cs_last   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_last = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_hist & ~w_cs_last;
  assign w_cs_rise   = ~r_cs_hist & w_cs_last;
  assign w_sclk_fall = r_sclk_hist & ~w_sclk_last;
  assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_load_word = {{LEAD_ZEROS{1'b0}}, sample_in};

  // CS_n rise is tested before SCLK fall so an abort beats a simultaneous last edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_sdata_out   <= 1'b0;
      r_sdata_oe    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_shift     <= w_load_word;
            r_bit_cnt   <= '0;
            r_sdata_out <= w_load_word[FRAME_LEN-1];
            r_sdata_oe  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_sdata_out   <= 1'b0;
            r_sdata_oe    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_abort <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (w_sclk_fall) begin
            if (w_last_bit) begin
              r_bit_cnt     <= r_bit_cnt + 1'b1;
              r_sdata_out   <= 1'b0;
              r_sdata_oe    <= 1'b0;
              r_busy        <= 1'b0;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 8'd1;
              r_state       <= ST_DONE;
            end else begin
              r_shift     <= {r_shift[FRAME_LEN-2:0], 1'b0};
              r_bit_cnt   <= r_bit_cnt + 1'b1;
              r_sdata_out <= r_shift[FRAME_LEN-2];
            end
          end
        end
        ST_DONE: begin
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_sdata_out <= 1'b0;
          r_sdata_oe  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdata_out   = r_sdata_out;
  assign sdata_oe    = r_sdata_oe;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign frame_count = r_frame_count;

endmodule
